// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle over XLEN cycles.
// Results are returned through a registered `result` with a one-cycle `done`.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, sampled on the rising edge
//   ALUOp      controller opcode class (2'b10 = R-type)
//   Funct7     instruction bits 31:25
//   Funct3     instruction bits 14:12 (selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   op_a       rs1 value
//   op_b       rs2 value
//   flush      synchronous abort, returns the unit to idle
//   is_muldiv  combinational M-extension decode
//   busy       high while an operation is in flight
//   done       one-cycle completion pulse, result valid during it
//   result     registered result
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            is_muldiv,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    // SETUP conditions the latched operands (signs, magnitudes, special cases)
    // one cycle after accept, before the iterative loop starts.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc;      // {hi, lo}: mul = {partial, multiplier}, div = {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
    logic              neg_q;    // negate product / quotient in FIX
    logic              neg_r;    // negate remainder in FIX
    logic [CW-1:0]     cnt;

    assign is_muldiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Operand conditioning from the latched request
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] min_neg;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] spec_val;

    always_comb begin
        is_div   = f3_q[2];
        a_signed = is_div ? ~f3_q[0] : (f3_q[1:0] != 2'b11);
        b_signed = is_div ? ~f3_q[0] : ~f3_q[1];
        sa       = a_signed & a_q[XLEN-1];
        sb       = b_signed & b_q[XLEN-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        div0     = is_div && (b_q == '0);
        ovf      = is_div && ~f3_q[0] && (a_q == min_neg) && (b_q == '1);
        if (div0) begin
            spec_val = f3_q[1] ? a_q : '1;
        end else begin
            spec_val = f3_q[1] ? '0 : a_q;
        end
    end

    // One iteration step for each algorithm
    logic [XLEN:0]     mul_add;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_add   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_add, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        // Borrow clear means the divisor fits: keep the difference, quotient bit 1
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and half selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        quo     = acc[XLEN-1:0];
        rem     = acc[2*XLEN-1:XLEN];
        if (f3_q[1]) begin
            div_res = neg_r ? -rem : rem;
        end else begin
            div_res = neg_q ? -quo : quo;
        end
        fix_val = f3_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            f3_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_muldiv) begin
                        f3_q  <= Funct3;
                        a_q   <= op_a;
                        b_q   <= op_b;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    if (div0 || ovf) begin
                        result <= spec_val;
                        state  <= DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        opnd  <= is_div ? mag_b : mag_a;
                        cnt   <= CW'(XLEN - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= f3_q[2] ? div_next : mul_next;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    result <= fix_val;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
